// File: rtl/trng_word_serializer.sv
// trng_word_serializer: parallel-in, serial-out converter for replaying TRNG
// words as a raw bit stream (loopback self-test or debug pin).
//
// Ports:
//   clk           system clock, rising edge
//   rst_i         asynchronous active-high reset
//   word_i        parallel word to serialize
//   word_valid_i  word_i is valid
//   word_ready_o  word is accepted this cycle (combinational from state, shift_en_i)
//   shift_en_i    bit strobe: consume current bit, present the next
//   bit_o         current serial bit (straight from the holding register)
//   bit_valid_o   bit_o holds a valid bit
//   last_bit_o    bit_o is the final bit of the current word
//   busy_o        a word is loaded and not yet fully emitted
//   word_cnt_o    number of fully emitted words, wraps modulo 2^CNT_W
module trng_word_serializer #(
  parameter int unsigned NBITS     = 32,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic [NBITS-1:0] word_i,
  input  logic             word_valid_i,
  output logic             word_ready_o,
  input  logic             shift_en_i,
  output logic             bit_o,
  output logic             bit_valid_o,
  output logic             last_bit_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] word_cnt_o
);

  localparam int unsigned BCNT_W = $clog2(NBITS + 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e            state;
  logic [NBITS-1:0]  hold_q;
  logic [NBITS-1:0]  hold_shifted;
  logic [BCNT_W-1:0] bit_cnt_q;
  logic [CNT_W-1:0]  word_cnt_q;
  logic              last_q;
  logic              armed_q;
  logic              word_done;
  logic              accept;

  // Next holding-register value: move toward the output end, zero-fill.
  always_comb begin
    hold_shifted = '0;
    if (MSB_FIRST) begin
      hold_shifted = {hold_q[NBITS-2:0], 1'b0};
    end else begin
      hold_shifted = {1'b0, hold_q[NBITS-1:1]};
    end
  end

  // armed_q keeps ready low through reset and until the first edge after it.
  assign word_done    = (state == ST_SHIFT) && last_q && shift_en_i;
  assign word_ready_o = ((state == ST_IDLE) && armed_q) || word_done;
  assign accept       = word_valid_i && word_ready_o;

  // Serializer FSM, holding register, bit and word counters.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      hold_q     <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      last_q     <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      if (word_done) begin
        word_cnt_q <= word_cnt_q + CNT_W'(1);
      end
      if (accept) begin
        // Covers both the IDLE load and the zero-bubble reload on completion.
        state     <= ST_SHIFT;
        hold_q    <= word_i;
        bit_cnt_q <= BCNT_W'(NBITS);
        last_q    <= 1'b0;
      end else if ((state == ST_SHIFT) && shift_en_i) begin
        hold_q    <= hold_shifted;
        bit_cnt_q <= bit_cnt_q - BCNT_W'(1);
        last_q    <= (bit_cnt_q == BCNT_W'(2));
        if (last_q) begin
          state <= ST_IDLE;
        end
      end
    end
  end

  assign bit_o       = MSB_FIRST ? hold_q[NBITS-1] : hold_q[0];
  assign bit_valid_o = (state == ST_SHIFT);
  assign busy_o      = (state == ST_SHIFT);
  assign last_bit_o  = last_q;
  assign word_cnt_o  = word_cnt_q;

endmodule

// File: tb/tb_trng_word_serializer.sv
// Bench for trng_word_serializer: three instances (8-bit MSB-first, 8-bit
// LSB-first, 32-bit MSB-first) checked every cycle against a bit-count model,
// plus literal stream checks and a serial-in loopback reconstruction.
module tb_trng_word_serializer;

  localparam int unsigned CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]    rst;
  logic [2:0]    valid;
  logic [2:0]    se;
  logic [2:0]    rdy, bo, bv, lb, bs;
  logic [63:0]   win [3];
  logic [CW-1:0] wc  [3];
  logic [7:0]    w0, w1;
  logic [31:0]   w2;

  assign w0 = win[0][7:0];
  assign w1 = win[1][7:0];
  assign w2 = win[2][31:0];

  trng_word_serializer #(.NBITS(8), .MSB_FIRST(1'b1), .CNT_W(CW)) dut_m8 (
    .clk(clk), .rst_i(rst[0]), .word_i(w0), .word_valid_i(valid[0]),
    .word_ready_o(rdy[0]), .shift_en_i(se[0]), .bit_o(bo[0]),
    .bit_valid_o(bv[0]), .last_bit_o(lb[0]), .busy_o(bs[0]), .word_cnt_o(wc[0]));

  trng_word_serializer #(.NBITS(8), .MSB_FIRST(1'b0), .CNT_W(CW)) dut_l8 (
    .clk(clk), .rst_i(rst[1]), .word_i(w1), .word_valid_i(valid[1]),
    .word_ready_o(rdy[1]), .shift_en_i(se[1]), .bit_o(bo[1]),
    .bit_valid_o(bv[1]), .last_bit_o(lb[1]), .busy_o(bs[1]), .word_cnt_o(wc[1]));

  trng_word_serializer #(.NBITS(32), .MSB_FIRST(1'b1), .CNT_W(CW)) dut_m32 (
    .clk(clk), .rst_i(rst[2]), .word_i(w2), .word_valid_i(valid[2]),
    .word_ready_o(rdy[2]), .shift_en_i(se[2]), .bit_o(bo[2]),
    .bit_valid_o(bv[2]), .last_bit_o(lb[2]), .busy_o(bs[2]), .word_cnt_o(wc[2]));

  int checks = 0;
  int errors = 0;

  // Instance configuration
  int nb  [3] = '{8, 8, 32};
  bit msb [3] = '{1'b1, 1'b0, 1'b1};

  // Model: word being emitted, bits still to emit, words completed, armed flag
  logic [63:0] m_word  [3] = '{64'd0, 64'd0, 64'd0};
  int          m_rem   [3] = '{0, 0, 0};
  int unsigned m_cnt   [3] = '{0, 0, 0};
  bit          m_armed [3] = '{1'b0, 1'b0, 1'b0};
  bit          m_acc;

  // Stream statistics observed on the DUT outputs
  logic [63:0] cap    [3] = '{64'd0, 64'd0, 64'd0};
  int          run    [3] = '{0, 0, 0};
  int          maxrun [3] = '{0, 0, 0};
  logic [31:0] sent [$];
  logic [31:0] exp_word;

  bit          e_rdy, e_bv, e_lb;
  logic [63:0] e_wc;

  int se_mode [3] = '{0, 0, 0};  // 0: low, 1: high, 2: toggle, 3: random

  task automatic chk(input string name, input int i, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got 0x%0h, expected 0x%0h", name, i, $time, act, expv);
    end
  endtask

  function automatic bit m_ready(input int i);
    return (m_armed[i] && m_rem[i] == 0) || (m_rem[i] == 1 && se[i]);
  endfunction

  // Bits already emitted = nb - rem; pick the next one by bit order.
  function automatic logic m_bit(input int i);
    int idx;
    idx = msb[i] ? (m_rem[i] - 1) : (nb[i] - m_rem[i]);
    return m_word[i][idx[5:0]];
  endfunction

  // Model step on each rising edge using the inputs stable before it.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst[i]) begin
        m_rem[i]   = 0;
        m_cnt[i]   = 0;
        m_armed[i] = 1'b0;
      end else begin
        m_acc = valid[i] && m_ready(i);
        if (m_rem[i] > 0 && se[i]) begin
          m_rem[i]--;
          if (m_rem[i] == 0) m_cnt[i]++;
        end
        if (m_acc) begin
          m_word[i] = win[i];
          m_rem[i]  = nb[i];
        end
        m_armed[i] = 1'b1;
      end
    end
  end

  // Compare on the falling edge, plus stream capture and loopback check.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst[i]) begin
        e_rdy = 1'b0; e_bv = 1'b0; e_lb = 1'b0; e_wc = 64'd0;
      end else begin
        e_rdy = m_ready(i);
        e_bv  = (m_rem[i] > 0);
        e_lb  = (m_rem[i] == 1);
        e_wc  = 64'(CW'(m_cnt[i]));
      end
      chk("word_ready", i, 64'(rdy[i]), 64'(e_rdy));
      chk("bit_valid",  i, 64'(bv[i]),  64'(e_bv));
      chk("busy",       i, 64'(bs[i]),  64'(e_bv));
      chk("last_bit",   i, 64'(lb[i]),  64'(e_lb));
      chk("word_cnt",   i, 64'(wc[i]),  e_wc);
      if (e_bv) chk("bit", i, 64'(bo[i]), 64'(m_bit(i)));
      if (rst[i]) chk("bit_in_reset", i, 64'(bo[i]), 64'd0);

      if (bv[i] && se[i]) cap[i] = {cap[i][62:0], bo[i]};
      if (bv[i]) begin
        run[i]++;
        if (run[i] > maxrun[i]) maxrun[i] = run[i];
      end else begin
        run[i] = 0;
      end

      if (i == 2 && bv[2] && se[2] && lb[2]) begin
        if (sent.size() == 0) begin
          chk("loopback_extra", 2, 64'd1, 64'd0);
        end else begin
          exp_word = sent.pop_front();
          chk("loopback", 2, 64'(cap[2][31:0]), 64'(exp_word));
        end
      end
    end
  end

  // Strobe generator, updated just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        case (se_mode[i])
          1:       se[i] = 1'b1;
          2:       se[i] = ~se[i];
          3:       se[i] = ($urandom_range(0, 3) != 0);
          default: se[i] = 1'b0;
        endcase
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats(input int i);
    cap[i]    = 64'd0;
    maxrun[i] = 0;
  endtask

  // Present a word and hold it until accepted.
  task automatic drive_word(input int i, input logic [63:0] w);
    int n;
    win[i]   = w;
    valid[i] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy[i] && n < 1000);
    chk("accept_timeout", i, 64'(rdy[i]), 64'd1);
    @(posedge clk);
    #1;
    valid[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bs[i] && n < 2000);
    chk("idle_timeout", i, 64'(bs[i]), 64'd0);
  endtask

  initial begin
    logic [31:0] w;
    int n;
    rst   = 3'b111;
    valid = 3'b000;
    se    = 3'b000;
    for (int i = 0; i < 3; i++) win[i] = 64'd0;

    // Reset state
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_ready", i, 64'(rdy[i]), 64'd0);
      chk("rst_valid", i, 64'(bv[i]),  64'd0);
      chk("rst_bit",   i, 64'(bo[i]),  64'd0);
      chk("rst_cnt",   i, 64'(wc[i]),  64'd0);
    end
    repeat (3) sync();
    rst = 3'b000;
    #1;
    chk("ready_before_edge", 0, 64'(rdy[0]), 64'd0);
    sync();
    chk("ready_after_edge", 0, 64'(rdy[0]), 64'd1);

    // MSB-first 0xC1
    se_mode[0] = 1;
    se_mode[1] = 1;
    clear_stats(0);
    drive_word(0, 64'hC1);
    wait_idle(0);
    chk("msb_stream", 0, 64'(cap[0][7:0]), 64'hC1);
    chk("msb_run",    0, 64'(maxrun[0]),   64'd8);
    chk("msb_cnt",    0, 64'(wc[0]),       64'd1);

    // LSB-first 0xC1 -> 1,0,0,0,0,0,1,1
    sync();
    clear_stats(1);
    drive_word(1, 64'hC1);
    wait_idle(1);
    chk("lsb_stream", 1, 64'(cap[1][7:0]), 64'h83);
    chk("lsb_cnt",    1, 64'(wc[1]),       64'd1);

    // Reset mid-word: three bits of 0xFF, then asynchronous reset
    sync();
    drive_word(0, 64'hFF);
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_valid", 0, 64'(bv[0]), 64'd1);
    #1;
    rst[0] = 1'b1;
    #1;
    chk("async_rst_valid", 0, 64'(bv[0]),  64'd0);
    chk("async_rst_bit",   0, 64'(bo[0]),  64'd0);
    chk("async_rst_busy",  0, 64'(bs[0]),  64'd0);
    chk("async_rst_last",  0, 64'(lb[0]),  64'd0);
    chk("async_rst_ready", 0, 64'(rdy[0]), 64'd0);
    chk("async_rst_cnt",   0, 64'(wc[0]),  64'd0);
    repeat (2) sync();
    rst[0] = 1'b0;
    #1;
    chk("rerst_ready_low", 0, 64'(rdy[0]), 64'd0);
    sync();
    chk("rerst_ready", 0, 64'(rdy[0]), 64'd1);
    chk("rerst_cnt",   0, 64'(wc[0]),  64'd0);
    clear_stats(0);
    drive_word(0, 64'h81);
    wait_idle(0);
    chk("post_rst_stream", 0, 64'(cap[0][7:0]), 64'h81);
    chk("post_rst_cnt",    0, 64'(wc[0]),       64'd1);

    // Back-to-back 0xC1, 0x5A: 16 contiguous valid cycles (count continues from 1)
    sync();
    clear_stats(0);
    drive_word(0, 64'hC1);
    drive_word(0, 64'h5A);
    wait_idle(0);
    chk("b2b_stream", 0, 64'(cap[0][15:0]), 64'hC15A);
    chk("b2b_run",    0, 64'(maxrun[0]),    64'd16);
    chk("b2b_cnt",    0, 64'(wc[0]),        64'd3);

    // Throttled: strobe toggles, first valid cycle has strobe low
    sync();
    se_mode[0] = 2;
    clear_stats(0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (se[0] !== 1'b1 && n < 10);
    chk("toggle_phase", 0, 64'(se[0]), 64'd1);
    win[0]   = 64'hC1;
    valid[0] = 1'b1;
    sync();
    valid[0] = 1'b0;
    wait_idle(0);
    chk("thr_stream", 0, 64'(cap[0][7:0]), 64'hC1);
    chk("thr_run",    0, 64'(maxrun[0]),   64'd16);
    chk("thr_cnt",    0, 64'(wc[0]),       64'd4);
    se_mode[0] = 0;

    // Loopback: 100 random 32-bit words with random strobes and gaps
    sync();
    se_mode[2] = 3;
    for (int k = 0; k < 100; k++) begin
      w = $urandom;
      sent.push_back(w);
      drive_word(2, 64'(w));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) sync();
    end
    wait_idle(2);
    chk("loopback_cnt",  2, 64'(wc[2]),       64'd100);
    chk("loopback_left", 2, 64'(sent.size()), 64'd0);

    repeat (2) sync();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/trng_word_serializer.md
Name: trng_word_serializer

Overview:
- Parallel-in, serial-out converter: the transmit-side counterpart of the TRNG sampling shift register.
- Accepts NBITS-wide words through a valid/ready handshake and emits them one bit per enabled cycle, with a bit-valid qualifier.
- Used to replay stored or reference words as a raw bit stream, either into the sampling shift register (loopback self-test) or out to a debug pin for external statistical testing.
- Bit ordering is chosen so that a serial-in shift register clocked with the same enable reconstructs the original word.

Parameters:
- NBITS, 32, word width in bits; legal range 2..64.
- MSB_FIRST, 1, 1 = word[NBITS-1] is emitted first; 0 = word[0] is emitted first.
- CNT_W, 16, width of the serialized-word counter.

Ports:
- clk  in  1  system clock; all state is updated on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- word_i  in  NBITS  parallel word to serialize.
- word_valid_i  in  1  word_i is valid.
- word_ready_o  out  1  block accepts word_i this cycle.
- shift_en_i  in  1  bit strobe; the current bit is consumed and the next bit is presented.
- bit_o  out  1  current serial bit.
- bit_valid_o  out  1  bit_o holds a valid bit.
- last_bit_o  out  1  bit_o is the final bit of the current word.
- busy_o  out  1  a word is loaded and not yet fully emitted.
- word_cnt_o  out  CNT_W  number of words fully emitted; wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, rst_i=1):
  - State goes to IDLE; holding register and bit counter go to 0.
  - All outputs go low: word_ready_o=0, bit_o=0, bit_valid_o=0, last_bit_o=0, busy_o=0, word_cnt_o=0.
  - word_ready_o rises on the first clk edge after rst_i deasserts.
  - Reset mid-word discards the in-flight word; word_cnt_o is not incremented.
- States: IDLE and SHIFT.
- IDLE:
  - word_ready_o=1, bit_valid_o=0; shift_en_i is ignored.
  - On word_valid_i & word_ready_o at a clock edge: load word_i into the holding register, set the bit counter to NBITS, go to SHIFT.
- SHIFT:
  - bit_valid_o=1 and busy_o=1.
  - bit_o = holding reg[NBITS-1] if MSB_FIRST, else holding reg[0]. bit_o comes directly from a register, with no combinational path from inputs.
  - last_bit_o = (bit counter == 1).
  - On an edge with shift_en_i=1: shift the holding register toward the output end (left if MSB_FIRST, right otherwise), zero-fill, decrement the bit counter.
  - On an edge with shift_en_i=0: bit_o and all state hold, for any number of cycles.
- Word completion (SHIFT & last_bit_o & shift_en_i), on that edge:
  - word_cnt_o increments by 1, wrapping from 2^CNT_W-1 to 0.
  - If word_valid_i=1: load the new word, bit counter = NBITS, stay in SHIFT. This gives a zero-bubble back-to-back stream.
  - Otherwise: go to IDLE.
- word_ready_o = IDLE | (SHIFT & last_bit_o & shift_en_i). This is combinational from state and shift_en_i only; it never depends on word_valid_i.
- word_valid_i while word_ready_o=0: the word is not consumed. The producer must hold word_i stable until accepted.
- Latency: the first bit is valid on bit_o the cycle after acceptance. A word occupies exactly NBITS enabled cycles.
- Loopback property:
  - Serializer with MSB_FIRST=1, feeding a serial-in shift register that shifts left with the new bit entering bit 0, both strobed by bit_valid_o & shift_en_i.
  - After NBITS strobes the shift register holds the original word.

Test Plan:
- Basic MSB-first (NBITS=8, MSB_FIRST=1): accept 0xC1, shift_en_i held at 1 → bit_o = 1,1,0,0,0,0,0,1 on 8 consecutive cycles. last_bit_o high only on the 8th; word_ready_o high in IDLE and on the 8th; word_cnt_o goes 0→1.
- LSB-first (MSB_FIRST=0): accept 0xC1 → bit_o = 1,0,0,0,0,0,1,1.
- Back-to-back: 0xC1 then 0x5A, word_valid_i held, shift_en_i=1 → 16 contiguous bit_valid_o cycles with no gap. Second word reads 0,1,0,1,1,0,1,0; word_cnt_o=2.
- Throttled: shift_en_i toggling 1,0,1,0… with 0xC1 → each bit held 2 cycles, word completes after 16 cycles, and bit_o is unchanged in every shift_en_i=0 cycle.
- Reset mid-word: assert rst_i after 3 bits of 0xFF → outputs drop immediately (asynchronously). After release: IDLE, word_ready_o=1, word_cnt_o=0. Next word 0x81 emits 1,0,0,0,0,0,0,1 with no residue.
- Loopback (NBITS=32): 100 random words into a serial-in shift register → every reconstructed word matches. Holding word_valid_i while busy never causes a double accept; word_cnt_o=100.
